ysyx_22041207_hazard_ctrl: RTL and testbench
============================================

YSYX_22041207_HAZARD_CTRL -- requirements
Module: ysyx_22041207_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..7: cycles of front-end flush per redirect or trap.
REQ-002 SHALL have port clk  input  1  sole clock; state and counters update on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports id_rs1addr, id_rs2addr  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 SHALL have ports ex_rwaddr  input  5, ex_writeRD  input  1, ex_memoryReadWen  input  1  destination, write-enable and load flag of the instruction in EX.
REQ-007 SHALL have ports ex_redirect  input  1  taken branch/jal/jalr resolved in EX; ex_trap  input  1  ecall/mret in EX.
REQ-008 SHALL have ports mem_req  input  1, mem_ready  input  1  data-memory handshake of the MEM stage.
REQ-009 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, clear_afterID, exmem_stall  1 each  pipeline-register controls.
REQ-010 SHALL have output redirect_fire  1  one-cycle pulse accepting a redirect or trap.
REQ-011 SHALL have output in_flush  1  high while in state FLUSH.
REQ-012 SHALL have outputs load_use_cnt, mem_wait_cnt  32 each  performance counters.

Function
REQ-013 SHALL implement two states, RUN and FLUSH, plus a 3-bit flush counter fcnt.
REQ-014 SHALL drive all control outputs combinationally from state and current inputs, settled before the negedge capture of the pipeline registers.
REQ-015 SHALL define mem_wait = mem_req & ~mem_ready.
REQ-016 SHALL define load_use = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 0) & ((id_use_rs1 & id_rs1addr == ex_rwaddr) | (id_use_rs2 & id_rs2addr == ex_rwaddr)).
REQ-017 SHALL apply priority mem_wait > trap > redirect > load_use in RUN.
REQ-018 In any state, mem_wait SHALL assert pc_stall, ifid_stall, idex_bubble and exmem_stall, and SHALL not fire redirect_fire; EX inputs are then treated as held and re-evaluated next cycle.
REQ-019 In RUN without mem_wait, ex_trap SHALL assert redirect_fire, ifid_flush and clear_afterID (not idex_flush) for that cycle.
REQ-020 In RUN without mem_wait or trap, ex_redirect SHALL assert redirect_fire, ifid_flush and idex_flush for that cycle.
REQ-021 On an accepted trap or redirect, state SHALL go to FLUSH with fcnt = FLUSH_CYCLES-1 if FLUSH_CYCLES > 1; otherwise it SHALL remain RUN.
REQ-022 In RUN with only load_use, outputs SHALL be pc_stall, ifid_stall and idex_flush for exactly one cycle (single bubble), with no state change; the next cycle sees no load in EX.
REQ-023 In FLUSH, ifid_flush and idex_flush SHALL assert every cycle.
REQ-024 In FLUSH, fcnt SHALL decrement each cycle without mem_wait and hold during mem_wait; at fcnt == 0 without mem_wait, the next state SHALL be RUN.
REQ-025 In FLUSH, ex_redirect, ex_trap and load_use SHALL be ignored.
REQ-026 With no condition active in RUN, all control outputs SHALL be 0.
REQ-027 load_use_cnt SHALL increment by 1 per cycle in which REQ-022 applies.
REQ-028 mem_wait_cnt SHALL increment by 1 per cycle with mem_wait.
REQ-029 Both counters SHALL wrap 0xFFFFFFFF -> 0.

Reset
REQ-030 While rst = 1, state SHALL be RUN, fcnt = 0, counters = 0, and all control outputs = 0 regardless of other inputs.
REQ-031 Reset asserted mid-FLUSH or mid-wait SHALL abort the sequence immediately (asynchronously).
REQ-032 After rst deasserts, the first posedge SHALL evaluate from RUN.

Verification
REQ-033 Load-use: EX = lw x5 (ex_rwaddr=5, load=1), ID uses rs1=5 -> one cycle of pc_stall/ifid_stall/idex_flush; load_use_cnt = 1; repeat with ex_rwaddr=0 -> no stall.
REQ-034 Redirect with FLUSH_CYCLES=3: ex_redirect pulse -> redirect_fire 1 cycle; ifid_flush/idex_flush high 3 consecutive cycles; in_flush high cycles 2-3; then RUN.
REQ-035 Mem wait: mem_req=1, mem_ready=0 for 4 cycles with ex_redirect=1 -> 4 cycles of full freeze, no redirect_fire, mem_wait_cnt = 4; redirect_fire on cycle 5.
REQ-036 Trap with simultaneous redirect and load_use -> clear_afterID and ifid_flush only, idex_flush = 0, load_use_cnt unchanged.
REQ-037 rst pulse during FLUSH (fcnt=2) -> outputs 0 at once, in_flush = 0, counters 0; redirect after release is accepted normally.
REQ-038 Counter wrap: preload mem_wait_cnt = 0xFFFFFFFF via force, one wait cycle -> 0.

Source files
------------

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, trap/redirect flush sequencing,
// single-bubble load-use interlock, plus stall performance counters.
module ysyx_22041207_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rwaddr,
  input  logic        ex_writeRD,
  input  logic        ex_memoryReadWen,
  input  logic        ex_redirect,
  input  logic        ex_trap,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_flush,
  output logic        clear_afterID,
  output logic        exmem_stall,
  output logic        redirect_fire,
  output logic        in_flush,
  output logic [31:0] load_use_cnt,
  output logic [31:0] mem_wait_cnt
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] load_use_cnt_q, load_use_cnt_d;
  logic [31:0] mem_wait_cnt_q, mem_wait_cnt_d;

  logic mem_wait;
  logic load_use;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) &
                    ((id_use_rs1 & (id_rs1addr == ex_rwaddr)) |
                     (id_use_rs2 & (id_rs2addr == ex_rwaddr)));

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    load_use_cnt_d = load_use_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    idex_flush     = 1'b0;
    clear_afterID  = 1'b0;
    exmem_stall    = 1'b0;
    redirect_fire  = 1'b0;
    in_flush       = 1'b0;

    // Outputs are forced quiet while reset is held, independent of the inputs.
    if (!rst) begin
      if (mem_wait) begin
        pc_stall       = 1'b1;
        ifid_stall     = 1'b1;
        idex_bubble    = 1'b1;
        exmem_stall    = 1'b1;
        mem_wait_cnt_d = mem_wait_cnt_q + 32'd1;
      end

      unique case (state_q)
        RUN: begin
          if (!mem_wait) begin
            if (ex_trap || ex_redirect) begin
              redirect_fire = 1'b1;
              ifid_flush    = 1'b1;
              clear_afterID = ex_trap;
              idex_flush    = ~ex_trap;
              if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FCNT_INIT;
              end
            end else if (load_use) begin
              pc_stall       = 1'b1;
              ifid_stall     = 1'b1;
              idex_flush     = 1'b1;
              load_use_cnt_d = load_use_cnt_q + 32'd1;
            end
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          in_flush   = 1'b1;
          // fcnt holds the flush cycles still owed; the last one returns to RUN.
          if (!mem_wait) begin
            if (fcnt_q <= 3'd1) begin
              state_d = RUN;
              fcnt_d  = 3'd0;
            end else begin
              fcnt_d = fcnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      fcnt_q         <= 3'd0;
      load_use_cnt_q <= 32'd0;
      mem_wait_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      load_use_cnt_q <= load_use_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
    end
  end

  assign load_use_cnt = load_use_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;

endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// Directed bench for ysyx_22041207_hazard_ctrl with FLUSH_CYCLES=3; control
// outputs are packed as {pc_stall,ifid_stall,ifid_flush,idex_bubble,idex_flush,
// clear_afterID,exmem_stall,redirect_fire,in_flush}.
module tb_ysyx_22041207_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1addr, id_rs2addr, ex_rwaddr;
  logic        id_use_rs1, id_use_rs2, ex_writeRD, ex_memoryReadWen;
  logic        ex_redirect, ex_trap, mem_req, mem_ready;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush;
  logic        clear_afterID, exmem_stall, redirect_fire, in_flush;
  logic [31:0] load_use_cnt, mem_wait_cnt;
  logic [8:0]  ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] IDLE   = 9'h000;
  localparam logic [8:0] LDUSE  = 9'h190;
  localparam logic [8:0] REDIR  = 9'h052;
  localparam logic [8:0] TRAP   = 9'h04A;
  localparam logic [8:0] FLSH   = 9'h051;
  localparam logic [8:0] WAIT   = 9'h1A4;
  localparam logic [8:0] FLWAIT = 9'h1F5;

  ysyx_22041207_hazard_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rwaddr(ex_rwaddr), .ex_writeRD(ex_writeRD), .ex_memoryReadWen(ex_memoryReadWen),
    .ex_redirect(ex_redirect), .ex_trap(ex_trap),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_flush(idex_flush), .clear_afterID(clear_afterID),
    .exmem_stall(exmem_stall), .redirect_fire(redirect_fire), .in_flush(in_flush),
    .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush,
                clear_afterID, exmem_stall, redirect_fire, in_flush};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [4:0] rs1, input logic use1,
                               input logic [4:0] rs2, input logic use2,
                               input logic [4:0] rw, input logic wrd, input logic ld,
                               input logic redir, input logic trap,
                               input logic req, input logic rdy);
    id_rs1addr = rs1; id_use_rs1 = use1;
    id_rs2addr = rs2; id_use_rs2 = use2;
    ex_rwaddr = rw; ex_writeRD = wrd; ex_memoryReadWen = ld;
    ex_redirect = redir; ex_trap = trap;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic clearInputs();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Combinational controls are compared at the negedge, well away from posedge.
  task automatic checkOutput(input string tag, input logic [8:0] exp);
    @(negedge clk);
    total++;
    assert (ctl === exp) else begin
      bad++;
      $error("[TB] FAIL %s ctl observed=%03h expected=%03h", tag, ctl, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_quiet", IDLE);
    tick();
    checkCount("reset_luc", load_use_cnt, 32'd0);
    checkCount("reset_mwc", mem_wait_cnt, 32'd0);
    rst = 1'b0;
    clearInputs();
    checkOutput("idle", IDLE);
    tick();

    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("loaduse_rs1", LDUSE);
    tick();
    clearInputs();
    checkCount("luc_1", load_use_cnt, 32'd1);
    checkOutput("after_bubble", IDLE);
    tick();

    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("loaduse_x0", IDLE);
    tick();
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rs2_unused", IDLE);
    tick();
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("loaduse_rs2", LDUSE);
    tick();
    clearInputs();
    checkCount("luc_2", load_use_cnt, 32'd2);

    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("redirect_fire", REDIR);
    tick();
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_ignores", FLSH);
    tick();
    clearInputs();
    checkOutput("flush_2", FLSH);
    tick();
    checkOutput("back_to_run", IDLE);
    checkCount("luc_flush", load_use_cnt, 32'd2);
    tick();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("memwait_%0d", i), WAIT);
      tick();
    end
    checkCount("mwc_4", mem_wait_cnt, 32'd4);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("redirect_after_wait", REDIR);
    tick();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_wait", FLWAIT);
    tick();
    clearInputs();
    checkCount("mwc_5", mem_wait_cnt, 32'd5);
    checkOutput("flush_held_1", FLSH);
    tick();
    checkOutput("flush_held_2", FLSH);
    tick();
    checkOutput("run_after_held", IDLE);
    tick();

    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("trap_priority", TRAP);
    tick();
    clearInputs();
    checkOutput("trap_flush_1", FLSH);
    tick();
    checkOutput("trap_flush_2", FLSH);
    tick();
    checkOutput("trap_done", IDLE);
    checkCount("luc_trap", load_use_cnt, 32'd2);
    tick();

    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("redirect_pre_rst", REDIR);
    tick();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++;
    assert (ctl === IDLE) else begin
      bad++;
      $error("[TB] FAIL rst_async ctl observed=%03h expected=%03h", ctl, IDLE);
    end
    checkCount("rst_async_luc", load_use_cnt, 32'd0);
    checkCount("rst_async_mwc", mem_wait_cnt, 32'd0);
    tick();
    checkCount("rst_hold_mwc", mem_wait_cnt, 32'd0);
    rst = 1'b0;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("redirect_post_rst", REDIR);
    tick();
    clearInputs();
    checkOutput("post_rst_flush_1", FLSH);
    tick();
    checkOutput("post_rst_flush_2", FLSH);
    tick();
    checkOutput("post_rst_run", IDLE);
    tick();

    force dut.mem_wait_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mem_wait_cnt_q;
    checkCount("mwc_preload", mem_wait_cnt, 32'hFFFF_FFFF);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_wait", WAIT);
    tick();
    checkCount("mwc_wrap", mem_wait_cnt, 32'd0);
    clearInputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
